// File: rtl/xtor_jtag_pkg.sv
// JTAG shift engine shared types and constants.
// Optional adaptive clocking is enabled by defining XTOR_JTAG_RTCK_EN.
package xtor_jtag_pkg;

    localparam int JTAG_MAX_BITS = 64;
    localparam int JTAG_LEN_W    = 7;
    localparam int JTAG_DIV_W    = 12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH,
        ST_RESP
    } jtag_state_e;

    // Lengths above the shift width are treated as a full-width command.
    function automatic logic [JTAG_LEN_W-1:0] clamp_len(
        input logic [JTAG_LEN_W-1:0] len
    );
        logic [JTAG_LEN_W-1:0] max_len;
        max_len = JTAG_LEN_W'(JTAG_MAX_BITS);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/xtor_jtag_shift_engine_halfper_cnt.sv
// Loadable down-counter timing one TCK half period.
// Terminal count is flagged while the count sits at zero.
module xtor_jtag_halfper_cnt #(
    parameter int DIV_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [DIV_W-1:0] load_val_i,
    output logic             tc_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/xtor_jtag_shift_engine.sv
// JTAG shift engine: shifts up to 64 TMS/TDI bits and captures TDO.
// Define XTOR_JTAG_RTCK_EN to let rtck_pos end the TCK high phase.
module xtor_jtag_shift_engine
    import xtor_jtag_pkg::*;
#(
    parameter int MAX_BITS = JTAG_MAX_BITS,
    parameter int DIV_W    = JTAG_DIV_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [JTAG_LEN_W-1:0] cmd_len,
    input  logic [MAX_BITS-1:0]   cmd_tms,
    input  logic [MAX_BITS-1:0]   cmd_tdi,
    input  logic [DIV_W-1:0]      clk_div,
    output logic                  tck,
    output logic                  tms,
    output logic                  tdi,
    input  logic                  tdo,
    input  logic                  rtck_pos,
    input  logic                  rtck_en,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [MAX_BITS-1:0]   rsp_tdo,
    output logic                  busy
);

    localparam int IDX_W = $clog2(MAX_BITS);

    jtag_state_e           state_q, state_d;
    logic [JTAG_LEN_W-1:0] len_q, len_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [MAX_BITS-1:0]   tms_sh_q, tms_sh_d;
    logic [MAX_BITS-1:0]   tdi_sh_q, tdi_sh_d;
    logic [MAX_BITS-1:0]   rsp_q, rsp_d;
    logic                  tms_q, tms_d;
    logic                  tdi_q, tdi_d;

    logic                  accept;
    logic                  cnt_tc;
    logic                  cnt_load;
    logic                  hi_done;
    logic                  last_bit;
    logic [JTAG_LEN_W-1:0] len_in;

    assign accept   = cmd_valid & cmd_ready;
    assign len_in   = clamp_len(cmd_len);
    assign last_bit = (JTAG_LEN_W'(idx_q) == len_q - JTAG_LEN_W'(1));

`ifdef XTOR_JTAG_RTCK_EN
    // Remembers an RTCK pulse that coincided with the rising TCK edge.
    logic seen_q, seen_d;

    always_comb begin
        seen_d = 1'b0;
        if (state_q == ST_LOW && cnt_tc) begin
            seen_d = rtck_pos;
        end else if (state_q == ST_HIGH) begin
            seen_d = seen_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seen_q <= 1'b0;
        end else begin
            seen_q <= seen_d;
        end
    end

    assign hi_done = rtck_en ? (seen_q | rtck_pos) : cnt_tc;
`else
    logic unused_rtck;
    assign unused_rtck = rtck_pos ^ rtck_en;
    assign hi_done     = cnt_tc;
`endif

    assign cnt_load = accept
                    | (state_q == ST_LOW  && cnt_tc)
                    | (state_q == ST_HIGH && hi_done);

    xtor_jtag_halfper_cnt #(
        .DIV_W (DIV_W)
    ) u_halfper_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i ((state_q == ST_IDLE) ? clk_div : div_q),
        .tc_o       (cnt_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = (len_in == '0) ? ST_RESP : ST_LOW;
                end
            end
            ST_LOW: begin
                if (cnt_tc) state_d = ST_HIGH;
            end
            ST_HIGH: begin
                if (hi_done) state_d = last_bit ? ST_RESP : ST_LOW;
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == ST_IDLE) & ~rst;
        busy      = (state_q != ST_IDLE);
        tck       = (state_q == ST_HIGH);
        rsp_valid = (state_q == ST_RESP);
        tms       = tms_q;
        tdi       = tdi_q;
        rsp_tdo   = rsp_q;
    end

    always_comb begin
        len_d    = len_q;
        idx_d    = idx_q;
        div_d    = div_q;
        tms_sh_d = tms_sh_q;
        tdi_sh_d = tdi_sh_q;
        rsp_d    = rsp_q;
        tms_d    = tms_q;
        tdi_d    = tdi_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    tms_sh_d = cmd_tms;
                    tdi_sh_d = cmd_tdi;
                    len_d    = len_in;
                    div_d    = clk_div;
                    rsp_d    = '0;
                    idx_d    = '0;
                    if (len_in != '0) begin
                        tms_d = cmd_tms[0];
                        tdi_d = cmd_tdi[0];
                    end
                end
            end
            ST_LOW: begin
                if (cnt_tc) rsp_d[idx_q] = tdo;
            end
            ST_HIGH: begin
                if (hi_done && !last_bit) begin
                    idx_d = idx_q + IDX_W'(1);
                    tms_d = tms_sh_q[idx_d];
                    tdi_d = tdi_sh_q[idx_d];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q    <= '0;
            idx_q    <= '0;
            div_q    <= '0;
            tms_sh_q <= '0;
            tdi_sh_q <= '0;
            rsp_q    <= '0;
            tms_q    <= 1'b1;
            tdi_q    <= 1'b0;
        end else begin
            len_q    <= len_d;
            idx_q    <= idx_d;
            div_q    <= div_d;
            tms_sh_q <= tms_sh_d;
            tdi_sh_q <= tdi_sh_d;
            rsp_q    <= rsp_d;
            tms_q    <= tms_d;
            tdi_q    <= tdi_d;
        end
    end

endmodule

// File: tb/tb_xtor_jtag_shift_engine.sv
// Directed bench for xtor_jtag_shift_engine with a per-cycle waveform model.
// Default build only (XTOR_JTAG_RTCK_EN undefined).
module tb_xtor_jtag_shift_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [6:0]  cmd_len = '0;
    logic [63:0] cmd_tms = '0;
    logic [63:0] cmd_tdi = '0;
    logic [11:0] clk_div = '0;
    logic        tck, tms, tdi, tdo;
    logic        rtck_pos = 1'b0;
    logic        rtck_en = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_tdo;
    logic        busy;

    logic loop_en = 1'b0;
    logic tdo_fix = 1'b0;
    assign tdo = loop_en ? tdi : tdo_fix;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    typedef struct packed {
        logic tck;
        logic tms;
        logic tdi;
        logic rv;
    } exp_t;

    exp_t exp_q[$];
    logic last_tms = 1'b1;
    logic last_tdi = 1'b0;

    xtor_jtag_shift_engine dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_len   (cmd_len),
        .cmd_tms   (cmd_tms),
        .cmd_tdi   (cmd_tdi),
        .clk_div   (clk_div),
        .tck       (tck),
        .tms       (tms),
        .tdi       (tdi),
        .tdo       (tdo),
        .rtck_pos  (rtck_pos),
        .rtck_en   (rtck_en),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_tdo   (rsp_tdo),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge tck) pulses++;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Per-cycle comparison of the pins against the model waveform.
    always @(negedge clk) begin : cmp
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("cycle", 64'({busy, cmd_ready, tck, tms, tdi, rsp_valid}),
                64'({1'b1, 1'b0, e.tck, e.tms, e.tdi, e.rv}));
        end
    end

    task automatic run_cmd(input int len, input logic [63:0] t_ms,
                           input logic [63:0] t_di, input int div,
                           input bit lp, input bit tf, input int hold,
                           input int lat_lit, input int pul_lit,
                           input bit use_lit, input logic [63:0] rsp_lit);
        int L;
        int n;
        int lat;
        logic [63:0] mask;
        logic [63:0] exp_rsp;
        L = (len > 64) ? 64 : len;
        mask = (L == 64) ? '1 : ((64'd1 << L) - 64'd1);
        exp_rsp = lp ? (t_di & mask) : (tf ? mask : 64'd0);
        lat = 2 * (div + 1) * L + 1;
        @(negedge clk);
        loop_en = lp;
        tdo_fix = tf;
        cmd_len = 7'(len);
        cmd_tms = t_ms;
        cmd_tdi = t_di;
        clk_div = 12'(div);
        cmd_valid = 1'b1;
        chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        pulses = 0;
        @(posedge clk);
        for (int b = 0; b < L; b++) begin
            for (int k = 0; k <= div; k++)
                exp_q.push_back({1'b0, t_ms[b], t_di[b], 1'b0});
            for (int k = 0; k <= div; k++)
                exp_q.push_back({1'b1, t_ms[b], t_di[b], 1'b0});
        end
        if (L > 0) begin
            last_tms = t_ms[L-1];
            last_tdi = t_di[L-1];
        end
        exp_q.push_back({1'b0, last_tms, last_tdi, 1'b1});
        @(negedge clk);
        n = 1;
        cmd_valid = 1'b0;
        cmd_tms = ~t_ms;
        cmd_tdi = ~t_di;
        clk_div = 12'hfff;
        while (!rsp_valid && n < lat + 20) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_latency", 64'(n), 64'(lat));
        if (lat_lit >= 0) chk("rsp_latency_lit", 64'(n), 64'(lat_lit));
        chk("pulses", 64'(pulses), 64'(L));
        if (pul_lit >= 0) chk("pulses_lit", 64'(pulses), 64'(pul_lit));
        chk("rsp_tdo", rsp_tdo, exp_rsp);
        if (use_lit) chk("rsp_tdo_lit", rsp_tdo, rsp_lit);
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1;
            cmd_len = 7'd3;
            @(negedge clk);
            chk("hold_ctl", 64'({rsp_valid, cmd_ready, busy}), 64'(3'b101));
            chk("hold_tdo", rsp_tdo, exp_rsp);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("resp_done", 64'({rsp_valid, cmd_ready, busy}), 64'(3'b010));
        chk("idle_pins", 64'({tck, tms, tdi}),
            64'({1'b0, last_tms, last_tdi}));
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_pins", 64'({tck, tms, tdi, rsp_valid, busy, cmd_ready}),
            64'(6'b010000));
        chk("reset_tdo", rsp_tdo, 64'd0);
        rst = 1'b0;

        run_cmd(5, 64'h1F, 64'h0, 0, 1'b0, 1'b1, 0, 11, 5, 1'b1, 64'h1F);
        run_cmd(64, 64'h0123_4567_89AB_CDEF, 64'hA5A5_0000_FFFF_1234, 3,
                1'b1, 1'b0, 0, 513, 64, 1'b1, 64'hA5A5_0000_FFFF_1234);
        run_cmd(0, '1, '1, 5, 1'b0, 1'b1, 0, 1, 0, 1'b1, 64'd0);
        run_cmd(100, 64'hDEAD_BEEF_CAFE_F00D, 64'h1357_9BDF_0246_8ACE, 1,
                1'b1, 1'b0, 0, 257, 64, 1'b0, 64'd0);
        run_cmd(3, 64'b101, 64'b011, 2, 1'b0, 1'b0, 20, 19, 3, 1'b1, 64'd0);

        // Abort a command during the high phase of bit 7.
        @(negedge clk);
        loop_en = 1'b1;
        cmd_len = 7'd20;
        cmd_tms = 64'hFFFF_0000_1234_5678;
        cmd_tdi = 64'h0F0F_0F0F_0F0F_0F0F;
        clk_div = 12'd0;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (15) @(negedge clk);
        chk("bit7_high", 64'(tck), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_pins", 64'({tck, tms, tdi, busy, rsp_valid, cmd_ready}),
            64'(6'b010000));
        chk("abort_tdo", rsp_tdo, 64'd0);
        rst = 1'b0;
        last_tms = 1'b1;
        last_tdi = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_rsp", 64'({rsp_valid, busy}), 64'd0);
        end

        run_cmd(9, 64'h155, 64'h0AA, 1, 1'b1, 1'b0, 0, 37, 9, 1'b1, 64'h0AA);
        run_cmd(1, 64'h0, 64'h1, 2, 1'b0, 1'b1, 0, 7, 1, 1'b1, 64'h1);

        repeat (2) @(negedge clk);
        chk("model_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/xtor_jtag_shift_engine.md
XTOR_JTAG_SHIFT_ENGINE -- requirements
Module: xtor_jtag_shift_engine

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports as listed below.
REQ-002 Parameter MAX_BITS, default 64: maximum bits per command; 64 is the only supported value.
REQ-003 Parameter DIV_W, default 12: width of the TCK half-period divider.
REQ-004 Port clk, input, 1: driver clock; all state updates on its posedge.
REQ-005 Port rst, input, 1: synchronous active-high reset.
REQ-006 Port cmd_valid, input, 1: command present.
REQ-007 Port cmd_ready, output, 1: engine accepts a command.
REQ-008 Port cmd_len, input, 7: bit count; 1..64 valid, 0 = no-op, values above 64 clamp to 64.
REQ-009 Port cmd_tms, input, 64: TMS bits; bit 0 is shifted first.
REQ-010 Port cmd_tdi, input, 64: TDI bits; bit 0 is shifted first.
REQ-011 Port clk_div, input, DIV_W: half-period is clk_div+1 clk cycles.
REQ-012 Port tck, output, 1: JTAG TCK.
REQ-013 Port tms, output, 1: JTAG TMS.
REQ-014 Port tdi, output, 1: JTAG TDI.
REQ-015 Port tdo, input, 1: JTAG TDO from the target.
REQ-016 Port rtck_pos, input, 1: one-cycle RTCK rising-edge pulse from the upstream clock-detect front.
REQ-017 Port rtck_en, input, 1: selects adaptive clocking; used only when the Configuration macro is defined.
REQ-018 Port rsp_valid, output, 1: captured TDO is available.
REQ-019 Port rsp_ready, input, 1: consumer accepts the response.
REQ-020 Port rsp_tdo, output, 64: captured TDO; bit i is the sample for shifted bit i; unused upper bits are 0.
REQ-021 Port busy, output, 1: engine is not in IDLE.

Function
REQ-022 The FSM SHALL have the states IDLE, LOW, HIGH and RESP; busy = (state != IDLE).
REQ-023 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a clk edge with cmd_valid && cmd_ready.
REQ-024 On accept, the engine SHALL latch tms, tdi, len (after clamping) and clk_div, clear rsp_tdo and the bit index, and go to LOW; if len == 0 it SHALL go to RESP instead.
REQ-025 In LOW: tck = 0, and tms/tdi SHALL drive bit[index] for clk_div+1 cycles, after which the FSM goes to HIGH.
REQ-026 On entry to HIGH, tck SHALL rise and tdo SHALL be captured into rsp_tdo[index] on that same edge.
REQ-027 HIGH SHALL last clk_div+1 cycles; at its end, index increments and the FSM goes to LOW if index < len-1, else to RESP with tck = 0.
REQ-028 Timing: rsp_valid SHALL assert exactly 2*(clk_div+1)*len+1 cycles after the accept edge; for len == 0 it SHALL assert on the cycle after accept.
REQ-029 In RESP, rsp_valid = 1 and rsp_tdo SHALL be stable until rsp_ready is sampled high; the FSM then returns to IDLE, and cmd_ready rises on the following cycle.
REQ-030 Changes to clk_div, cmd_* or rtck_pos while the FSM is not in IDLE SHALL have no effect, except rtck_pos as stated under Configuration.
REQ-031 tms and tdi SHALL hold their last driven values in RESP and IDLE.

Reset
REQ-032 When rst is high, the engine SHALL enter IDLE on the next clk edge, regardless of the current state.
REQ-033 Reset values: tck = 0, tms = 1, tdi = 0, rsp_valid = 0, rsp_tdo = 0, busy = 0, cmd_ready = 0 while rst is high.
REQ-034 A reset during LOW, HIGH or RESP SHALL abort the command with no response issued.

Configuration
REQ-035 Macro XTOR_JTAG_RTCK_EN: when defined and rtck_en = 1, HIGH SHALL end on the first rtck_pos pulse seen in HIGH, not by the divider; a pulse on the entry edge counts. LOW still uses the divider.
REQ-036 Without XTOR_JTAG_RTCK_EN, rtck_pos and rtck_en SHALL be ignored and the block SHALL contain no adaptive-clock logic.

Structure
REQ-037 Package xtor_jtag_pkg SHALL hold the FSM state enum, JTAG_MAX_BITS = 64, JTAG_LEN_W = 7 and JTAG_DIV_W = 12.
REQ-038 The block SHALL contain one sub-module, xtor_jtag_halfper_cnt: a loadable DIV_W down-counter with a terminal-count output.

Verification
REQ-039 clk_div = 0, len = 5, tms = 0x1F, tdi = 0 -> 5 tck pulses, each 1 cycle high and 1 cycle low; tms = 1 throughout; rsp_valid asserts 11 cycles after accept.
REQ-040 clk_div = 3, len = 64, tdi = 0xA5A5_0000_FFFF_1234, tdo looped back to tdi -> rsp_tdo = 0xA5A5_0000_FFFF_1234; rsp_valid asserts after 513 cycles.
REQ-041 len = 0 -> no tck edge; rsp_valid on the cycle after accept with rsp_tdo = 0; len = 100 -> exactly 64 pulses.
REQ-042 rsp_ready held low for 20 cycles -> rsp_valid and rsp_tdo are stable, cmd_ready = 0, and a pending cmd_valid is not accepted.
REQ-043 rst asserted during HIGH of bit 7 -> next cycle tck = 0, tms = 1, busy = 0, no rsp_valid; a new command then completes correctly.
REQ-044 With XTOR_JTAG_RTCK_EN and rtck_en = 1, rtck_pos given 9 cycles after each tck rise -> each HIGH phase lasts 10 cycles, independent of clk_div = 0.
